// File: rtl/imem_responder_pkg.sv
// Shared types, constants and address-check helper for the instruction-memory responder.
// The IMEM_LOAD_EN build option is handled in imem_responder.sv.
package imem_responder_pkg;

  localparam logic [31:0] IMEM_NOP = 32'h0000_0000;
  localparam int unsigned IMEM_RSP_W = 65;

  typedef enum logic [1:0] {
    IMEM_ERR_NONE     = 2'd0,
    IMEM_ERR_MISALIGN = 2'd1,
    IMEM_ERR_RANGE    = 2'd2
  } imem_err_e;

  typedef struct packed {
    logic        err;
    logic [31:0] addr;
    logic [31:0] instr;
  } imem_rsp_t;

  // Index arithmetic is 32-bit unsigned, so an address below base wraps and lands out of range.
  function automatic imem_err_e imem_addr_check(input logic [31:0] addr,
                                                input logic [31:0] base,
                                                input logic [31:0] depth);
    logic [31:0] idx;
    idx = (addr - base) >> 2;
    if (addr[1:0] != 2'b00) begin
      return IMEM_ERR_MISALIGN;
    end else if ((addr < base) || (idx >= depth)) begin
      return IMEM_ERR_RANGE;
    end else begin
      return IMEM_ERR_NONE;
    end
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Synchronous response FIFO ({err, addr, instr}) with a same-edge clear used for redirect flush.
module imem_rsp_fifo
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = IMEM_RSP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pop_ok_s;
  logic             push_ok_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  always_comb begin
    pop_ok_s  = pop && (cnt_q != '0) && !clr;
    push_ok_s = push && !clr;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    if (clr) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset: the head is only used while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      store_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = store_q[rd_ptr_q];
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: pipelined synchronous word read, response FIFO, credit flow, flush.
// Define IMEM_LOAD_EN to add the ld_* program-load write port; otherwise the memory is a ROM.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [31:0] rsp_addr,
  output logic        rsp_err
`ifdef IMEM_LOAD_EN
  ,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
`endif
);

  localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  if ((LATENCY < 1) || (LATENCY > 4)) begin : g_lat_chk
    $error("imem_responder: LATENCY must be within 1..4");
  end
  if (FIFO_DEPTH < LATENCY + 1) begin : g_fifo_chk
    $warning("imem_responder: FIFO_DEPTH below LATENCY+1 limits throughput");
  end

  logic [31:0]        mem_q [DEPTH_WORDS];
  logic [31:0]        rd_data_q;
  logic [IW-1:0]      rd_idx_s;
  imem_err_e          req_code_s;
  logic               req_err_s;
  logic               accept_s;
  logic               pop_s;
  logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  imem_rsp_t          pipe_q [LATENCY];
  imem_rsp_t          pipe_d [LATENCY];
  imem_rsp_t          pipe_view_s [LATENCY];
  logic [CW-1:0]      outst_q, outst_d;
  logic               last_vld_s;
  logic               fifo_push_s;
  logic               fifo_pop_s;
  logic               fifo_empty_s;
  logic [IMEM_RSP_W-1:0] fifo_head_s;
  logic               rsp_valid_s;
  imem_rsp_t          rsp_sel_s;

`ifdef IMEM_LOAD_EN
  logic          ld_ok_s;
  logic [IW-1:0] ld_idx_s;

  always_comb begin
    ld_ok_s  = (imem_addr_check(ld_addr, BASE_ADDR, 32'(DEPTH_WORDS)) == IMEM_ERR_NONE);
    ld_idx_s = IW'((ld_addr - BASE_ADDR) >> 2);
  end

  // Write lands after the same-edge read samples the array, giving read-before-write.
  always_ff @(posedge clk) begin
    if (ld_we && ld_ok_s) begin
      mem_q[ld_idx_s] <= ld_data;
    end
  end
`endif

  always_comb begin
    req_code_s = imem_addr_check(req_addr, BASE_ADDR, 32'(DEPTH_WORDS));
    req_err_s  = (req_code_s != IMEM_ERR_NONE);
    rd_idx_s   = IW'((req_addr - BASE_ADDR) >> 2);
  end

  // Faulting fetches never touch the array.
  always_ff @(posedge clk) begin
    if (accept_s && !req_err_s) begin
      rd_data_q <= mem_q[rd_idx_s];
    end
  end

  // Stage 0 carries metadata only; its word comes straight from the read register.
  always_comb begin
    for (int k = 0; k < LATENCY; k++) begin
      pipe_view_s[k] = pipe_q[k];
    end
    if (pipe_vld_q[0] && !pipe_q[0].err) begin
      pipe_view_s[0].instr = rd_data_q;
    end else begin
      pipe_view_s[0].instr = IMEM_NOP;
    end
  end

  always_comb begin
    pipe_vld_d    = '0;
    pipe_vld_d[0] = accept_s;
    pipe_d[0]     = '{err: req_err_s, addr: req_addr, instr: IMEM_NOP};
    for (int k = 1; k < LATENCY; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1] && !req_flush;
      pipe_d[k]     = pipe_view_s[k-1];
    end
  end

  // The oldest pipeline entry bypasses the FIFO when the FIFO is empty.
  always_comb begin
    last_vld_s  = pipe_vld_q[LATENCY-1];
    rsp_valid_s = !fifo_empty_s || last_vld_s;
    if (fifo_empty_s) begin
      rsp_sel_s = pipe_view_s[LATENCY-1];
    end else begin
      rsp_sel_s = imem_rsp_t'(fifo_head_s);
    end
    pop_s       = rsp_valid_s && rsp_ready;
    fifo_pop_s  = !fifo_empty_s && rsp_ready;
    fifo_push_s = last_vld_s && !(fifo_empty_s && rsp_ready);
    req_ready   = !rst && !req_flush && ((outst_q < CW'(FIFO_DEPTH)) || pop_s);
    accept_s    = req_valid && req_ready;
  end

  always_comb begin
    outst_d = outst_q;
    if (req_flush) begin
      outst_d = '0;
    end else begin
      case ({accept_s, pop_s})
        2'b10:   outst_d = outst_q + CW'(1);
        2'b01:   outst_d = outst_q - CW'(1);
        default: outst_d = outst_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_q <= '0;
      outst_q    <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        pipe_q[k] <= '0;
      end
    end else begin
      pipe_vld_q <= pipe_vld_d;
      outst_q    <= outst_d;
      for (int k = 0; k < LATENCY; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

  imem_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (IMEM_RSP_W)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (req_flush),
    .push  (fifo_push_s),
    .din   (pipe_view_s[LATENCY-1]),
    .pop   (fifo_pop_s),
    .dout  (fifo_head_s),
    .empty (fifo_empty_s)
  );

  assign rsp_valid = rsp_valid_s;
  assign rsp_instr = rsp_sel_s.instr;
  assign rsp_addr  = rsp_sel_s.addr;
  assign rsp_err   = rsp_sel_s.err;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios plus randomized traffic against
// a queue-based model of outstanding fetches (each with the cycle it becomes visible).
module tb_imem_responder;

  localparam int unsigned DW   = 1024;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          L    = 2;
  localparam int          FD   = 4;
`ifdef IMEM_LOAD_EN
  localparam bit LD_EN = 1'b1;
`else
  localparam bit LD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_flush;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_instr, rsp_addr;
  logic        ld_we;
  logic [31:0] ld_addr, ld_data;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
    int          avail;
  } exp_t;

  exp_t        mq[$];
  logic [31:0] img [DW];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;

  imem_responder #(
    .DEPTH_WORDS (DW),
    .BASE_ADDR   (BASE),
    .LATENCY     (L),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_flush (req_flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err)
`ifdef IMEM_LOAD_EN
    ,
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < BASE) || (((a - BASE) >> 2) >= DW);
  endfunction

  // One clock period: drive at negedge, check mid-cycle, then advance the model at the edge.
  task automatic step(input bit v, input logic [31:0] a, input bit rr, input bit fl, input bit rs,
                      input bit lw, input logic [31:0] la, input logic [31:0] ldd);
    bit   ev, er;
    exp_t e;
    @(negedge clk);
    req_valid = v;  req_addr = a;  rsp_ready = rr;  req_flush = fl;  rst = rs;
    ld_we = lw;     ld_addr = la;  ld_data = ldd;
    #1;
    if (rs) mq.delete();
    ev = (mq.size() > 0) && (cyc >= mq[0].avail);
    chk_eq("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev) begin
      chk_eq("rsp_instr", rsp_instr, mq[0].instr);
      chk_eq("rsp_addr", rsp_addr, mq[0].addr);
      chk_eq("rsp_err", 32'(rsp_err), 32'(mq[0].err));
    end
    er = !rs && !fl && ((mq.size() < FD) || (ev && rr));
    chk_eq("req_ready", 32'(req_ready), 32'(er));
    @(posedge clk);
    cyc++;
    if (!rs) begin
      if (ev && rr) void'(mq.pop_front());
      if (fl) begin
        mq.delete();
      end else if (v && er) begin
        e.addr  = a;
        e.err   = bad(a);
        e.instr = e.err ? 32'h0 : img[(a - BASE) >> 2];
        e.avail = cyc + L - 1;
        mq.push_back(e);
      end
      if (LD_EN && lw && !bad(la)) img[(la - BASE) >> 2] = ldd;
    end
  endtask

  task automatic fetch(input logic [31:0] a, input bit rr);
    step(1'b1, a, rr, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, rr, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    bit          v, rr, fl, rs, lw;
    logic [31:0] a, la;
    int          r;
    rst = 1'b1;  req_valid = 1'b0;  req_addr = 32'h0;  req_flush = 1'b0;  rsp_ready = 1'b0;
    ld_we = 1'b0;  ld_addr = 32'h0;  ld_data = 32'h0;
    for (int i = 0; i < int'(DW); i++) begin
      img[i] = $urandom;
      dut.mem_q[i] = img[i];
    end
    repeat (2) @(negedge clk);
    #1;
    chk_eq("reset rsp_valid", 32'(rsp_valid), 32'h0);
    chk_eq("reset rsp_instr", rsp_instr, 32'h0);
    chk_eq("reset rsp_addr", rsp_addr, 32'h0);
    chk_eq("reset rsp_err", 32'(rsp_err), 32'h0);
    chk_eq("reset req_ready", 32'(req_ready), 32'h0);

    // Back-to-back fetches with a ready consumer.
    idle(1, 1'b1);
    fetch(32'h0, 1'b1);  fetch(32'h4, 1'b1);  fetch(32'h8, 1'b1);
    idle(4, 1'b1);

    // Consumer stalled: credit runs out after FIFO_DEPTH accepts, then drains in order.
    for (int i = 0; i < 7; i++) fetch(32'(i) << 2, 1'b0);
    idle(8, 1'b1);

    // Misaligned and out-of-range, then a good fetch.
    fetch(32'h2, 1'b1);  fetch(32'h1000, 1'b1);  fetch(32'h4, 1'b1);
    idle(4, 1'b1);

    // Redirect flush drops wrong-path fetches; request during flush is not taken.
    fetch(32'h10, 1'b0);  fetch(32'h14, 1'b0);
    step(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    fetch(32'h40, 1'b1);
    idle(4, 1'b1);

    // Reset with outstanding fetches, then a fetch right after release.
    fetch(32'h0, 1'b0);  fetch(32'h4, 1'b0);  fetch(32'h8, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    fetch(32'h0, 1'b1);
    idle(4, 1'b1);

`ifdef IMEM_LOAD_EN
    step(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 32'hDEAD_BEEF);
    fetch(32'h8, 1'b1);
    idle(4, 1'b1);
`endif

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      v  = ($urandom_range(0, 3) != 0);
      rr = (n % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 29) == 0);
      rs = ($urandom_range(0, 149) == 0);
      lw = LD_EN && ($urandom_range(0, 7) == 0);
      r  = $urandom_range(0, 9);
      if (r < 7)       a = 32'($urandom_range(0, DW - 1)) << 2;
      else if (r == 7) a = (32'($urandom_range(0, DW - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
      else             a = $urandom;
      la = 32'($urandom_range(0, 15)) << 2;
      step(v, a, rr, fl, rs, lw, la, $urandom);
    end
    idle(10, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
